// File: rtl/btn_debounce_if.sv
// Switch-conditioning bundle: raw pins and flag clears in, clean levels, edge pulses and sticky flags out.
interface btn_debounce_if #(
    parameter int N = 4
);
    logic [N-1:0] sw_in;
    logic [N-1:0] ev_clr;
    logic [N-1:0] sw_out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] ev_flags;

    // Plain level signals, no valid/ready: the board side (master) drives pins and clears,
    // the debouncer (slave) drives conditioned levels, one-cycle pulses and sticky flags.
    modport master (
        output sw_in, ev_clr,
        input  sw_out, rise, fall, ev_flags
    );

    modport slave (
        input  sw_in, ev_clr,
        output sw_out, rise, fall, ev_flags
    );
endinterface

// File: rtl/btn_debounce.sv
// N-channel switch debouncer: 2-flop synchroniser, per-channel stability counter,
// registered rise/fall pulses and sticky press flags with synchronous clear.
module btn_debounce #(
    parameter int           N         = 4,
    parameter int           DB_CYCLES = 50000,
    parameter logic [N-1:0] INIT      = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    btn_debounce_if.slave    bus
);
    localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  level;
    logic [N-1:0]  rise_q;
    logic [N-1:0]  fall_q;
    logic [N-1:0]  flags_q;
    logic [CW-1:0] cnt [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= INIT;
            s2      <= INIT;
            level   <= INIT;
            rise_q  <= '0;
            fall_q  <= '0;
            flags_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= bus.sw_in;
            s2     <= s1;
            rise_q <= '0;
            fall_q <= '0;
            // A pending rise sets the flag even if a clear arrives in the same cycle.
            flags_q <= rise_q | (flags_q & ~bus.ev_clr);
            for (int i = 0; i < N; i++) begin
                if (s2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < CNT_MAX) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else begin
                    level[i]  <= s2[i];
                    cnt[i]    <= '0;
                    rise_q[i] <= s2[i];
                    fall_q[i] <= ~s2[i];
                end
            end
        end
    end

    assign bus.sw_out   = level;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.ev_flags = flags_q;
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random toggling, checked every cycle
// against a sliding-window model of "input disagreed with the level for DB consecutive cycles".
module tb_btn_debounce;
  localparam int           N    = 4;
  localparam int           DB   = 8;
  localparam logic [N-1:0] INIT = '0;

  logic clk;
  logic rst_n;

  btn_debounce_if #(.N(N)) bus ();

  btn_debounce #(.N(N), .DB_CYCLES(DB), .INIT(INIT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  logic [N-1:0]   m_s1, m_s2, m_out, m_rise, m_fall, m_flags;
  logic [N-1:0]   win_q[$];
  logic [4*N-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = INIT; m_s2 = INIT; m_out = INIT;
    m_rise = '0; m_fall = '0; m_flags = '0;
    win_q.delete();
    for (int j = 0; j < DB; j++) win_q.push_back(INIT);
  endtask

  // One rising edge: a channel flips when its synchronised value differed from the
  // current level at each of the last DB edges (window includes this edge's value).
  task automatic model_edge();
    logic [N-1:0] acc;
    logic [N-1:0] nflags;
    bit ok;
    if (!rst_n) begin
      model_reset();
    end else begin
      nflags = m_rise | (m_flags & ~bus.ev_clr);
      win_q.push_back(m_s2);
      while (win_q.size() > DB) void'(win_q.pop_front());
      acc = '0;
      for (int i = 0; i < N; i++) begin
        ok = 1'b1;
        for (int j = 0; j < DB; j++) if (win_q[j][i] == m_out[i]) ok = 1'b0;
        acc[i] = ok;
      end
      m_rise  = acc & ~m_out;
      m_fall  = acc & m_out;
      m_out   = m_out ^ acc;
      m_flags = nflags;
      m_s2    = m_s1;
      m_s1    = bus.sw_in;
    end
    exp_q.push_back({m_flags, m_fall, m_rise, m_out});
  endtask

  // Advance one cycle: model the edge, compare after it, return at the next falling edge.
  task automatic step();
    logic [4*N-1:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check_eq("sw_out",   bus.sw_out,   e[N-1:0]);
    check_eq("rise",     bus.rise,     e[2*N-1:N]);
    check_eq("fall",     bus.fall,     e[3*N-1:2*N]);
    check_eq("ev_flags", bus.ev_flags, e[4*N-1:3*N]);
    check_eq("no_rise_fall_overlap", bus.rise & bus.fall, 0);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    model_reset();
    rst_n      = 1'b0;
    bus.sw_in  = 4'hF;
    bus.ev_clr = '0;
    @(negedge clk);

    // 1: reset holds everything at INIT, then all channels accept F on the 10th edge
    run(3);
    check_eq("reset_sw_out", bus.sw_out, 0);
    check_eq("reset_flags", bus.ev_flags, 0);
    rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 9)  check_eq("t1_rise_early", bus.rise, 0);
      if (n == 10) check_eq("t1_rise_at_10", bus.rise, 4'hF);
      if (n == 10) check_eq("t1_out_at_10", bus.sw_out, 4'hF);
      if (n == 11) check_eq("t1_flags_at_11", bus.ev_flags, 4'hF);
      if (n == 11) check_eq("t1_rise_single", bus.rise, 0);
    end
    bus.ev_clr = 4'hF; run(1); bus.ev_clr = '0;
    bus.sw_in = '0; run(12);

    // 2: 7-cycle pulse rejected; 20-cycle pulse with a 1-cycle dip accepted after the dip
    bus.sw_in[0] = 1'b1; run(7); bus.sw_in[0] = 1'b0; run(12);
    check_eq("t2_glitch_out", bus.sw_out[0], 0);
    check_eq("t2_glitch_flag", bus.ev_flags[0], 0);
    bus.sw_in[0] = 1'b1; run(5); bus.sw_in[0] = 1'b0; run(1); bus.sw_in[0] = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      step();
      if (n == 9)  check_eq("t2_dip_early", bus.sw_out[0], 0);
      if (n == 10) check_eq("t2_dip_rise", bus.rise[0], 1);
    end
    bus.sw_in[0] = 1'b0; run(12);

    // 3: exact threshold on channel 1; fall leaves the flag alone
    bus.sw_in[1] = 1'b1; run(12);
    bus.sw_in[1] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 10) check_eq("t3_fall_at_10", bus.fall[1], 1);
      if (n == 11) check_eq("t3_fall_single", bus.fall[1], 0);
    end
    check_eq("t3_flag_kept", bus.ev_flags[1], 1);
    // exactly DB-1 cycles of disagreement at s2 rejected, DB accepted
    bus.sw_in[1] = 1'b1; run(DB - 1); bus.sw_in[1] = 1'b0; run(12);
    check_eq("t3_dbm1_rejected", bus.sw_out[1], 0);
    bus.sw_in[1] = 1'b1; run(DB); bus.sw_in[1] = 1'b0; run(2);
    check_eq("t3_db_accepted", bus.sw_out[1], 1);
    run(12);

    // 4: clear coinciding with rise loses, then a lone clear wins
    bus.ev_clr = 4'hF; run(1); bus.ev_clr = '0;
    bus.sw_in[2] = 1'b1;
    for (int n = 0; n < 14; n++) begin
      bus.ev_clr[2] = m_rise[2];
      step();
    end
    bus.ev_clr = '0;
    check_eq("t4_set_wins", bus.ev_flags[2], 1);
    bus.ev_clr[2] = 1'b1; step(); bus.ev_clr[2] = 1'b0;
    check_eq("t4_clear", bus.ev_flags[2], 0);
    bus.sw_in[2] = 1'b0; run(12);

    // 5: reset mid-count discards partial progress
    bus.sw_in[3] = 1'b1; run(7);
    rst_n = 1'b0; run(2); rst_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 9)  check_eq("t5_no_carry", bus.rise[3], 0);
      if (n == 10) check_eq("t5_rise_at_10", bus.rise[3], 1);
    end
    bus.sw_in[3] = 1'b0; run(12);

    // 6: offset toggles on channels 0 and 2, then random activity on all channels
    for (int r = 0; r < 4; r++) begin
      bus.sw_in[0] = ~bus.sw_in[0]; run(3);
      bus.sw_in[2] = ~bus.sw_in[2]; run(12);
    end
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) bus.sw_in[i] = ~bus.sw_in[i];
        bus.ev_clr[i] = ($urandom_range(0, 7) == 0);
      end
      if (c == 1000) rst_n = 1'b0;
      if (c == 1002) rst_n = 1'b1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
